fb_csr_unit: RTL and testbench
==============================

FB_CSR_UNIT -- requirements
Module: fb_csr_unit

Interface
REQ-001 Parameter XLEN, default 32, data width of CSR read/write path and counters.
REQ-002 Parameter NUM_SCRATCH, default 4, number of general read/write scratch CSRs (1..12).
REQ-003 Parameter ADDR_W, default 4, CSR address width; 2^ADDR_W SHALL be >= 3+NUM_SCRATCH.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 csr_valid  input  1  CSR access request this cycle.
REQ-007 csr_op  input  2  00 READ, 01 WRITE, 10 SET (OR), 11 CLEAR (AND-NOT).
REQ-008 csr_addr  input  ADDR_W  0 FLAGS, 1 CYCLE, 2 INSTRET, 3..2+NUM_SCRATCH scratch.
REQ-009 csr_wdata  input  XLEN  write operand / bit mask.
REQ-010 csr_rdata  output  XLEN  pre-update value of addressed CSR (combinational).
REQ-011 csr_illegal  output  1  access rejected (combinational).
REQ-012 flag_we  input  1  ALU flag update strobe.
REQ-013 flag_in  input  4  {N,Z,C,V} from ALU.
REQ-014 retire  input  1  one instruction retired this cycle.
REQ-015 NF, ZF, CF, VF  output  1 each  registered flag bits, FLAGS[3:0].

Function
REQ-016 FLAGS: bits [3:0] = {NF,ZF,CF,VF}; bits [XLEN-1:4] read 0, writes ignored.
REQ-017 flag_we=1 SHALL load flag_in[3:0] into NF,ZF,CF,VF at next edge.
REQ-018 CYCLE SHALL increment by 1 every cycle rst=0; wraps all-ones -> 0.
REQ-019 INSTRET SHALL increment by 1 on each edge with retire=1; wraps all-ones -> 0.
REQ-020 CYCLE, INSTRET read-only; scratch CSRs read/write, XLEN bits, no side effects.
REQ-021 csr_rdata = old value of addressed CSR when csr_valid=1 and legal; 0 otherwise.
REQ-022 New value: WRITE wdata; SET old|wdata; CLEAR old&~wdata; applied at next edge; READ never writes.
REQ-023 SET/CLEAR with csr_wdata=0 SHALL be a pure read (no write, legal on read-only CSRs).
REQ-024 csr_illegal=1 iff csr_valid=1 and (addr > 2+NUM_SCRATCH, or addr in {1,2} with WRITE, or addr in {1,2} with SET/CLEAR and wdata!=0).
REQ-025 Illegal access SHALL change no state; counters continue normally.
REQ-026 Same cycle legal CSR write to FLAGS and flag_we=1: CSR write wins, flag_in discarded.
REQ-027 flag_we same cycle as READ of FLAGS: csr_rdata returns pre-update flags; update still applied.
REQ-028 Read of CYCLE/INSTRET returns value before this cycle's increment.
REQ-029 Single-cycle operation; no stall, no busy state; back-to-back accesses every cycle supported.

Reset
REQ-030 rst=1 at edge: NF=ZF=CF=VF=0, CYCLE=0, INSTRET=0, all scratch=0; overrides flag_we, retire, csr writes same cycle.
REQ-031 First edge after rst deasserts: CYCLE becomes 1.
REQ-032 During rst=1 combinational outputs follow current register values (csr_rdata, csr_illegal still decoded).

Verification
REQ-033 Reset then 10 idle cycles -> READ addr 1 returns 10; READ addr 0 returns 0; NF..VF=0.
REQ-034 flag_we=1, flag_in=4'b1010 -> next cycle NF=1,ZF=0,CF=1,VF=0; READ addr 0 returns 32'h0000000A.
REQ-035 WRITE addr 3 data 32'hF0F0_00FF; SET 32'h0000_0F00; CLEAR 32'h0000_000F -> READ returns 32'hF0F0_0FF0; each op's rdata shows prior value.
REQ-036 WRITE addr 1 -> csr_illegal=1, CYCLE unchanged in sequence; SET addr 2 wdata 0 -> legal, rdata=INSTRET; addr 7 (NUM_SCRATCH=4) -> illegal, rdata 0.
REQ-037 Same cycle WRITE addr 0 data 4'b0001 and flag_we with 4'b1110 -> flags = 0001 next cycle.
REQ-038 Force INSTRET near wrap via 2^XLEN retires (or XLEN=8 build): all-ones + retire -> 0; rst asserted mid-run with retire=1 -> INSTRET=0, CYCLE=0.

Source files
------------

// File: rtl/fb_csr_unit.sv
//==============================================================================
// Module      : fb_csr_unit
// Description : Small CSR block holding the ALU condition flags, a free-running
//               cycle counter, a retired-instruction counter and a bank of
//               general-purpose scratch registers. Accesses take one cycle:
//               read data is the pre-update value, and the write takes effect
//               at the next rising edge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   XLEN        : data width of the CSR path and counters (>= 4)
//   NUM_SCRATCH : number of read/write scratch CSRs (1..12)
//   ADDR_W      : CSR address width, 2**ADDR_W >= 3 + NUM_SCRATCH
// Ports
//   clk         : clock, all state changes on the rising edge
//   rst         : synchronous active-high reset
//   csr_valid   : CSR access request this cycle
//   csr_op      : 00 READ, 01 WRITE, 10 SET, 11 CLEAR
//   csr_addr    : 0 FLAGS, 1 CYCLE, 2 INSTRET, 3.. scratch
//   csr_wdata   : write operand / bit mask
//   csr_rdata   : old value of the addressed CSR, 0 when idle or illegal
//   csr_illegal : access rejected
//   flag_we     : ALU flag update strobe
//   flag_in     : {N,Z,C,V} from the ALU
//   retire      : one instruction retired this cycle
//   NF/ZF/CF/VF : registered flag bits
//==============================================================================
`default_nettype none

module fb_csr_unit #(
    parameter int XLEN        = 32,
    parameter int NUM_SCRATCH = 4,
    parameter int ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csr_valid,
    input  logic [1:0]        csr_op,
    input  logic [ADDR_W-1:0] csr_addr,
    input  logic [XLEN-1:0]   csr_wdata,
    output logic [XLEN-1:0]   csr_rdata,
    output logic              csr_illegal,
    input  logic              flag_we,
    input  logic [3:0]        flag_in,
    input  logic              retire,
    output logic              NF,
    output logic              ZF,
    output logic              CF,
    output logic              VF
);

    localparam logic [1:0] c_OP_READ  = 2'b00;
    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_SET   = 2'b10;
    localparam logic [1:0] c_OP_CLEAR = 2'b11;

    localparam logic [ADDR_W-1:0] c_ADDR_FLAGS   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] c_ADDR_CYCLE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_INSTRET = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] c_ADDR_MAX     = ADDR_W'(2 + NUM_SCRATCH);

    logic [3:0]      r_flags;
    logic [XLEN-1:0] r_cycle;
    logic [XLEN-1:0] r_instret;
    logic [XLEN-1:0] r_scratch [NUM_SCRATCH];

    logic            w_out_of_range;
    logic            w_read_only;
    logic            w_modifies;
    logic            w_illegal;
    logic            w_do_write;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_new;

    //--------------------------------------------------------------------------
    // Access decode. SET/CLEAR with a zero mask cannot change anything, so it
    // is treated as a read; that makes it legal on the read-only counters.
    //--------------------------------------------------------------------------
    assign w_out_of_range = (csr_addr > c_ADDR_MAX);
    assign w_read_only    = (csr_addr == c_ADDR_CYCLE) || (csr_addr == c_ADDR_INSTRET);
    assign w_modifies     = (csr_op == c_OP_WRITE) ||
                            ((csr_op != c_OP_READ) && (csr_wdata != '0));
    assign w_illegal      = csr_valid && (w_out_of_range || (w_read_only && w_modifies));
    assign w_do_write     = csr_valid && !w_illegal && w_modifies;

    // Old value of the addressed CSR; FLAGS upper bits always read as zero.
    always_comb begin
        w_old = '0;
        if (csr_addr == c_ADDR_FLAGS) begin
            w_old[3:0] = r_flags;
        end else if (csr_addr == c_ADDR_CYCLE) begin
            w_old = r_cycle;
        end else if (csr_addr == c_ADDR_INSTRET) begin
            w_old = r_instret;
        end
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (csr_addr == ADDR_W'(i + 3)) begin
                w_old = r_scratch[i];
            end
        end
    end

    always_comb begin
        w_new = w_old;
        case (csr_op)
            c_OP_WRITE: w_new = csr_wdata;
            c_OP_SET:   w_new = w_old | csr_wdata;
            c_OP_CLEAR: w_new = w_old & ~csr_wdata;
            default:    w_new = w_old;
        endcase
    end

    assign csr_rdata   = (csr_valid && !w_illegal) ? w_old : '0;
    assign csr_illegal = w_illegal;

    //--------------------------------------------------------------------------
    // Flags: a legal CSR write to FLAGS takes priority over the ALU strobe.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= 4'b0000;
        end else if (w_do_write && (csr_addr == c_ADDR_FLAGS)) begin
            r_flags <= w_new[3:0];
        end else if (flag_we) begin
            r_flags <= flag_in;
        end
    end

    // Counters run independently of any CSR access, legal or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (retire) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                r_scratch[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (w_do_write && (csr_addr == ADDR_W'(i + 3))) begin
                    r_scratch[i] <= w_new;
                end
            end
        end
    end

    assign NF = r_flags[3];
    assign ZF = r_flags[2];
    assign CF = r_flags[1];
    assign VF = r_flags[0];

endmodule

`default_nettype wire

// File: tb/tb_fb_csr_unit.sv
//==============================================================================
// Module      : tb_fb_csr_unit
// Description : Scoreboard bench for fb_csr_unit. A 32-bit instance covers the
//               CSR functions; an 8-bit instance makes counter wrap reachable.
//               Stimulus pushes expected responses; a negedge monitor pops and
//               compares whenever an instance has csr_valid asserted.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fb_csr_unit;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        illegal;
        logic        chk_flags;
        logic [3:0]  flags;
    } exp_t;

    logic        clk;
    // 32-bit instance
    logic        rst;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [3:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        flag_we;
    logic [3:0]  flag_in;
    logic        retire;
    logic        NF, ZF, CF, VF;
    // 8-bit instance
    logic        rst8;
    logic        valid8;
    logic [1:0]  op8;
    logic [3:0]  addr8;
    logic [7:0]  wdata8;
    logic [7:0]  rdata8;
    logic        illegal8;
    logic        flag_we8;
    logic [3:0]  flag_in8;
    logic        retire8;
    logic        nf8, zf8, cf8, vf8;

    exp_t q32[$];
    exp_t q8[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] exp_cycle   = '0;
    logic [31:0] exp_instret = '0;

    fb_csr_unit #(.XLEN(32), .NUM_SCRATCH(4), .ADDR_W(4)) u_dut (
        .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_op(csr_op),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal), .flag_we(flag_we), .flag_in(flag_in),
        .retire(retire), .NF(NF), .ZF(ZF), .CF(CF), .VF(VF)
    );

    fb_csr_unit #(.XLEN(8), .NUM_SCRATCH(4), .ADDR_W(4)) u_dut8 (
        .clk(clk), .rst(rst8), .csr_valid(valid8), .csr_op(op8),
        .csr_addr(addr8), .csr_wdata(wdata8), .csr_rdata(rdata8),
        .csr_illegal(illegal8), .flag_we(flag_we8), .flag_in(flag_in8),
        .retire(retire8), .NF(nf8), .ZF(zf8), .CF(cf8), .VF(vf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    //--------------------------------------------------------------------------
    // Monitor
    //--------------------------------------------------------------------------
    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (csr_valid) begin
            if (q32.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut32_unexpected: access with empty scoreboard");
            end else begin
                e = q32.pop_front();
                cmp({e.name, ".rdata"}, csr_rdata, e.rdata);
                cmp({e.name, ".illegal"}, {31'd0, csr_illegal}, {31'd0, e.illegal});
                if (e.chk_flags)
                    cmp({e.name, ".flags"}, {28'd0, NF, ZF, CF, VF}, {28'd0, e.flags});
            end
        end
        if (valid8) begin
            if (q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut8_unexpected: access with empty scoreboard");
            end else begin
                e = q8.pop_front();
                cmp({e.name, ".rdata"}, {24'd0, rdata8}, e.rdata);
                cmp({e.name, ".illegal"}, {31'd0, illegal8}, {31'd0, e.illegal});
            end
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus helpers
    //--------------------------------------------------------------------------
    // Advance one clock; the bench's counter reference follows the 32-bit DUT.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            exp_cycle   = '0;
            exp_instret = '0;
        end else begin
            exp_cycle = exp_cycle + 1;
            if (retire) exp_instret = exp_instret + 1;
        end
        #1;
    endtask

    task automatic issue(input string nm, input logic [1:0] op, input logic [3:0] addr,
                         input logic [31:0] wd, input logic [31:0] er, input logic ei,
                         input logic cf, input logic [3:0] ef);
        exp_t e;
        csr_valid = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wd;
        e.name = nm; e.rdata = er; e.illegal = ei; e.chk_flags = cf; e.flags = ef;
        q32.push_back(e);
        tick();
        csr_valid = 1'b0;
    endtask

    task automatic issue8(input string nm, input logic [1:0] op, input logic [3:0] addr,
                          input logic [7:0] wd, input logic [31:0] er, input logic ei);
        exp_t e;
        valid8 = 1'b1;
        op8    = op;
        addr8  = addr;
        wdata8 = wd;
        e.name = nm; e.rdata = er; e.illegal = ei; e.chk_flags = 1'b0; e.flags = 4'h0;
        q8.push_back(e);
        tick();
        valid8 = 1'b0;
    endtask

    //--------------------------------------------------------------------------
    // Directed sequence
    //--------------------------------------------------------------------------
    initial begin
        logic [31:0] c0;
        rst = 1'b1; csr_valid = 1'b0; csr_op = OP_READ; csr_addr = '0; csr_wdata = '0;
        flag_we = 1'b0; flag_in = '0; retire = 1'b0;
        rst8 = 1'b1; valid8 = 1'b0; op8 = OP_READ; addr8 = '0; wdata8 = '0;
        flag_we8 = 1'b0; flag_in8 = '0; retire8 = 1'b0;

        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        issue("cycle_after_10", OP_READ, 4'd1, 32'd0, 32'd10, 1'b0, 1'b0, 4'h0);
        issue("flags_reset",    OP_READ, 4'd0, 32'd0, 32'd0,  1'b0, 1'b1, 4'h0);

        flag_we = 1'b1; flag_in = 4'b1010;
        tick();
        flag_we = 1'b0;
        issue("flags_load", OP_READ, 4'd0, 32'd0, 32'h0000_000A, 1'b0, 1'b1, 4'hA);

        retire = 1'b1;
        repeat (3) tick();
        retire = 1'b0;

        issue("scr_write", OP_WRITE, 4'd3, 32'hF0F0_00FF, 32'h0000_0000, 1'b0, 1'b0, 4'h0);
        issue("scr_set",   OP_SET,   4'd3, 32'h0000_0F00, 32'hF0F0_00FF, 1'b0, 1'b0, 4'h0);
        issue("scr_clear", OP_CLEAR, 4'd3, 32'h0000_000F, 32'hF0F0_0FFF, 1'b0, 1'b0, 4'h0);
        issue("scr_read",  OP_READ,  4'd3, 32'h0000_0000, 32'hF0F0_0FF0, 1'b0, 1'b0, 4'h0);

        c0 = exp_cycle;
        issue("cycle_write_ill",  OP_WRITE, 4'd1, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0, 4'h0);
        issue("cycle_in_seq",     OP_READ,  4'd1, 32'd0, c0 + 32'd1, 1'b0, 1'b0, 4'h0);
        issue("instret_set0",     OP_SET,   4'd2, 32'd0, 32'd3, 1'b0, 1'b0, 4'h0);
        issue("instret_set_ill",  OP_SET,   4'd2, 32'd5, 32'd0, 1'b1, 1'b0, 4'h0);
        issue("cycle_clear0",     OP_CLEAR, 4'd1, 32'd0, exp_cycle, 1'b0, 1'b0, 4'h0);
        issue("addr7_read_ill",   OP_READ,  4'd7, 32'd0, 32'd0, 1'b1, 1'b0, 4'h0);
        issue("addr7_write_ill",  OP_WRITE, 4'd7, 32'h123, 32'd0, 1'b1, 1'b0, 4'h0);
        issue("addr15_ill",       OP_READ,  4'd15, 32'd0, 32'd0, 1'b1, 1'b0, 4'h0);
        issue("scr_last_write",   OP_WRITE, 4'd6, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 4'h0);
        issue("scr_last_read",    OP_READ,  4'd6, 32'd0, 32'h1234_5678, 1'b0, 1'b0, 4'h0);
        issue("scr4_untouched",   OP_READ,  4'd4, 32'd0, 32'd0, 1'b0, 1'b0, 4'h0);
        issue("instret_after",    OP_READ,  4'd2, 32'd0, 32'd3, 1'b0, 1'b0, 4'h0);

        // CSR write beats the ALU strobe.
        flag_we = 1'b1; flag_in = 4'b1110;
        issue("flags_wr_vs_we", OP_WRITE, 4'd0, 32'h0000_0001, 32'h0000_000A, 1'b0, 1'b1, 4'hA);
        flag_we = 1'b0;
        issue("flags_wr_won", OP_READ, 4'd0, 32'd0, 32'h1, 1'b0, 1'b1, 4'h1);
        // Read alongside a strobe returns the old flags, update still lands.
        flag_we = 1'b1; flag_in = 4'b0101;
        issue("flags_rd_vs_we", OP_READ, 4'd0, 32'd0, 32'h1, 1'b0, 1'b1, 4'h1);
        flag_we = 1'b0;
        issue("flags_we_landed", OP_READ, 4'd0, 32'd0, 32'h5, 1'b0, 1'b1, 4'h5);
        issue("flags_wr_all",    OP_WRITE, 4'd0, 32'hFFFF_FFFF, 32'h5, 1'b0, 1'b0, 4'h0);
        issue("flags_upper_zero", OP_READ, 4'd0, 32'd0, 32'hF, 1'b0, 1'b1, 4'hF);
        issue("flags_clear",     OP_CLEAR, 4'd0, 32'h0000_000C, 32'hF, 1'b0, 1'b0, 4'h0);
        issue("flags_set",       OP_SET,   4'd0, 32'h0000_0008, 32'h3, 1'b0, 1'b1, 4'h3);
        issue("flags_after_set", OP_READ,  4'd0, 32'd0, 32'hB, 1'b0, 1'b1, 4'hB);

        // Reset overrides a simultaneous write, strobe and retire.
        rst = 1'b1; retire = 1'b1; flag_we = 1'b1; flag_in = 4'hF;
        issue("rst_write_decoded", OP_WRITE, 4'd3, 32'h0000_AAAA, 32'hF0F0_0FF0, 1'b0, 1'b1, 4'hB);
        retire = 1'b0; flag_we = 1'b0;
        issue("rst_scratch_zero", OP_READ, 4'd3, 32'd0, 32'd0, 1'b0, 1'b1, 4'h0);
        rst = 1'b0;
        issue("rst_cycle_zero",   OP_READ, 4'd1, 32'd0, 32'd0, 1'b0, 1'b0, 4'h0);
        issue("rst_cycle_one",    OP_READ, 4'd1, 32'd0, 32'd1, 1'b0, 1'b0, 4'h0);
        issue("rst_instret_zero", OP_READ, 4'd2, 32'd0, 32'd0, 1'b0, 1'b0, 4'h0);
        issue("rst_scr_last",     OP_READ, 4'd6, 32'd0, 32'd0, 1'b0, 1'b0, 4'h0);

        // 8-bit instance: counter wrap and reset during retire.
        rst8 = 1'b0; retire8 = 1'b1;
        repeat (255) tick();
        issue8("w8_instret_max",  OP_READ, 4'd2, 8'd0, 32'd255, 1'b0);
        retire8 = 1'b0;
        issue8("w8_instret_wrap", OP_READ, 4'd2, 8'd0, 32'd0, 1'b0);
        retire8 = 1'b1;
        issue8("w8_cycle_wrap",   OP_READ, 4'd1, 8'd0, 32'd1, 1'b0);
        rst8 = 1'b1;
        issue8("w8_rst_decoded",  OP_READ, 4'd2, 8'd0, 32'd1, 1'b0);
        issue8("w8_rst_instret",  OP_READ, 4'd2, 8'd0, 32'd0, 1'b0);
        issue8("w8_rst_cycle",    OP_READ, 4'd1, 8'd0, 32'd0, 1'b0);
        rst8 = 1'b0; retire8 = 1'b0;
        issue8("w8_cycle_zero",   OP_READ, 4'd1, 8'd0, 32'd0, 1'b0);
        issue8("w8_cycle_one",    OP_READ, 4'd1, 8'd0, 32'd1, 1'b0);
        issue8("w8_addr7_ill",    OP_SET,  4'd7, 8'd1, 32'd0, 1'b1);

        tick();
        cmp("q32_drained", q32.size(), 32'd0);
        cmp("q8_drained",  q8.size(),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
